// File: rtl/control_pipeline_pkg.sv
// Shared encodings for the EX operand forwarding selects.
// Pure constants, no logic.
package control_pipeline_pkg;
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
endpackage

// File: rtl/control_pipeline_hazard_detector.sv
// Load-use hazard detection and EX operand forwarding selects.
// Latency: purely combinational; backpressure: none, it only produces selects.
module hazard_detector
    import control_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_d_valid,
    input  logic [REG_ADDR_W-1:0] i_d_rs1,
    input  logic [REG_ADDR_W-1:0] i_d_rs2,
    input  logic                  i_d_use_rs1,
    input  logic                  i_d_use_rs2,
    input  logic                  i_e_valid,
    input  logic                  i_e_mem_reg,
    input  logic [REG_ADDR_W-1:0] i_e_rd,
    input  logic [REG_ADDR_W-1:0] i_e_rs1,
    input  logic [REG_ADDR_W-1:0] i_e_rs2,
    input  logic                  i_e_use_rs1,
    input  logic                  i_e_use_rs2,
    input  logic                  i_m_valid,
    input  logic                  i_m_de_we,
    input  logic                  i_m_mem_reg,
    input  logic [REG_ADDR_W-1:0] i_m_rd,
    input  logic                  i_w_valid,
    input  logic                  i_w_de_we,
    input  logic [REG_ADDR_W-1:0] i_w_rd,
    output logic                  o_hazard,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b
);
    logic w_m_src;
    logic w_w_src;

    // A load in MEM has no data yet, so it can only be forwarded once it reaches WB.
    assign w_m_src = i_m_valid & i_m_de_we & ~i_m_mem_reg & (i_m_rd != '0);
    assign w_w_src = i_w_valid & i_w_de_we & (i_w_rd != '0);

    assign o_hazard = i_d_valid & i_e_valid & i_e_mem_reg & (i_e_rd != '0)
                    & ((i_d_use_rs1 & (i_d_rs1 == i_e_rd))
                     | (i_d_use_rs2 & (i_d_rs2 == i_e_rd)));

    always_comb begin
        o_fwd_a = FWD_NONE;
        o_fwd_b = FWD_NONE;
        if (w_m_src && i_e_use_rs1 && (i_m_rd == i_e_rs1)) begin
            o_fwd_a = FWD_MEM;
        end else if (w_w_src && i_e_use_rs1 && (i_w_rd == i_e_rs1)) begin
            o_fwd_a = FWD_WB;
        end
        if (w_m_src && i_e_use_rs2 && (i_m_rd == i_e_rs2)) begin
            o_fwd_b = FWD_MEM;
        end else if (w_w_src && i_e_use_rs2 && (i_w_rd == i_e_rs2)) begin
            o_fwd_b = FWD_WB;
        end
    end
endmodule

// File: rtl/control_pipeline.sv
// EX/MEM/WB control pipeline with load-use stall, branch flush and event counters.
// Latency: one stage per clk; backpressure: none beyond holding decode on a stall.
module control_pipeline
    import control_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  d_valid,
    input  logic [1:0]            d_alu_op,
    input  logic [1:0]            d_alu_src2,
    input  logic                  d_brn_cond,
    input  logic                  d_mem_we,
    input  logic                  d_de_we,
    input  logic                  d_mem_reg,
    input  logic [REG_ADDR_W-1:0] d_rd,
    input  logic [REG_ADDR_W-1:0] d_rs1,
    input  logic [REG_ADDR_W-1:0] d_rs2,
    input  logic                  d_use_rs1,
    input  logic                  d_use_rs2,
    input  logic                  e_br_taken,
    output logic [1:0]            e_alu_op,
    output logic [1:0]            e_alu_src2,
    output logic                  e_brn_cond,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  m_mem_we,
    output logic                  w_de_we,
    output logic                  w_mem_reg,
    output logic [REG_ADDR_W-1:0] w_rd,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    logic                  r_e_valid, r_e_brn_cond, r_e_mem_we, r_e_de_we, r_e_mem_reg;
    logic [1:0]            r_e_alu_op, r_e_alu_src2;
    logic [REG_ADDR_W-1:0] r_e_rd, r_e_rs1, r_e_rs2;
    logic                  r_e_use_rs1, r_e_use_rs2;
    logic                  r_m_valid, r_m_mem_we, r_m_de_we, r_m_mem_reg;
    logic [REG_ADDR_W-1:0] r_m_rd;
    logic                  r_w_valid, r_w_de_we, r_w_mem_reg;
    logic [REG_ADDR_W-1:0] r_w_rd;
    logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;
    logic                  w_hazard, w_load_e;

    hazard_detector #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
        .i_d_valid  (d_valid),     .i_d_rs1    (d_rs1),       .i_d_rs2    (d_rs2),
        .i_d_use_rs1(d_use_rs1),   .i_d_use_rs2(d_use_rs2),
        .i_e_valid  (r_e_valid),   .i_e_mem_reg(r_e_mem_reg), .i_e_rd     (r_e_rd),
        .i_e_rs1    (r_e_rs1),     .i_e_rs2    (r_e_rs2),
        .i_e_use_rs1(r_e_use_rs1), .i_e_use_rs2(r_e_use_rs2),
        .i_m_valid  (r_m_valid),   .i_m_de_we  (r_m_de_we),   .i_m_mem_reg(r_m_mem_reg),
        .i_m_rd     (r_m_rd),
        .i_w_valid  (r_w_valid),   .i_w_de_we  (r_w_de_we),   .i_w_rd     (r_w_rd),
        .o_hazard   (w_hazard),    .o_fwd_a    (fwd_a),       .o_fwd_b    (fwd_b)
    );

    // A taken branch overrides the stall: the dependant is discarded anyway.
    assign flush_d  = e_br_taken & r_e_valid;
    assign stall_d  = w_hazard & ~flush_d;
    assign w_load_e = d_valid & ~flush_d & ~stall_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e_valid <= 1'b0; r_e_alu_op <= '0; r_e_alu_src2 <= '0; r_e_brn_cond <= 1'b0;
            r_e_mem_we <= 1'b0; r_e_de_we <= 1'b0; r_e_mem_reg <= 1'b0;
            r_e_rd <= '0; r_e_rs1 <= '0; r_e_rs2 <= '0; r_e_use_rs1 <= 1'b0; r_e_use_rs2 <= 1'b0;
            r_m_valid <= 1'b0; r_m_mem_we <= 1'b0; r_m_de_we <= 1'b0; r_m_mem_reg <= 1'b0;
            r_m_rd <= '0;
            r_w_valid <= 1'b0; r_w_de_we <= 1'b0; r_w_mem_reg <= 1'b0; r_w_rd <= '0;
            r_stall_cnt <= '0; r_flush_cnt <= '0;
        end else begin
            // Bubbles and idle slots carry all-zero fields so nothing stale leaks downstream.
            r_e_valid    <= w_load_e;
            r_e_alu_op   <= w_load_e ? d_alu_op   : '0;
            r_e_alu_src2 <= w_load_e ? d_alu_src2 : '0;
            r_e_brn_cond <= w_load_e & d_brn_cond;
            r_e_mem_we   <= w_load_e & d_mem_we;
            r_e_de_we    <= w_load_e & d_de_we;
            r_e_mem_reg  <= w_load_e & d_mem_reg;
            r_e_rd       <= w_load_e ? d_rd  : '0;
            r_e_rs1      <= w_load_e ? d_rs1 : '0;
            r_e_rs2      <= w_load_e ? d_rs2 : '0;
            r_e_use_rs1  <= w_load_e & d_use_rs1;
            r_e_use_rs2  <= w_load_e & d_use_rs2;
            r_m_valid    <= r_e_valid;
            r_m_mem_we   <= r_e_mem_we;
            r_m_de_we    <= r_e_de_we;
            r_m_mem_reg  <= r_e_mem_reg;
            r_m_rd       <= r_e_rd;
            r_w_valid    <= r_m_valid;
            r_w_de_we    <= r_m_de_we;
            r_w_mem_reg  <= r_m_mem_reg;
            r_w_rd       <= r_m_rd;
            if (stall_d && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush_d && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign e_alu_op   = r_e_valid ? r_e_alu_op   : '0;
    assign e_alu_src2 = r_e_valid ? r_e_alu_src2 : '0;
    assign e_brn_cond = r_e_valid & r_e_brn_cond;
    assign m_mem_we   = r_m_valid & r_m_mem_we;
    assign w_de_we    = r_w_valid & r_w_de_we;
    assign w_mem_reg  = r_w_valid & r_w_mem_reg;
    assign w_rd       = r_w_valid ? r_w_rd : '0;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
endmodule

// File: tb/tb_control_pipeline.sv
// Directed vector bench for control_pipeline plus a 4-bit counter instance for saturation.
module tb_control_pipeline;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, d_valid, d_brn_cond, d_mem_we, d_de_we, d_mem_reg, d_use_rs1, d_use_rs2, e_br_taken;
    logic [1:0] d_alu_op, d_alu_src2;
    logic [4:0] d_rd, d_rs1, d_rs2;

    logic [1:0]  e_alu_op, e_alu_src2, fwd_a, fwd_b;
    logic        e_brn_cond, m_mem_we, w_de_we, w_mem_reg, stall_d, flush_d;
    logic [4:0]  w_rd;
    logic [31:0] stall_cnt, flush_cnt;

    logic [1:0]  s_e_alu_op, s_e_alu_src2, s_fwd_a, s_fwd_b;
    logic        s_e_brn_cond, s_m_mem_we, s_w_de_we, s_w_mem_reg, s_stall_d, s_flush_d;
    logic [4:0]  s_w_rd;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    control_pipeline #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_alu_op(d_alu_op), .d_alu_src2(d_alu_src2),
        .d_brn_cond(d_brn_cond), .d_mem_we(d_mem_we), .d_de_we(d_de_we), .d_mem_reg(d_mem_reg),
        .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_br_taken(e_br_taken), .e_alu_op(e_alu_op), .e_alu_src2(e_alu_src2), .e_brn_cond(e_brn_cond),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .m_mem_we(m_mem_we), .w_de_we(w_de_we), .w_mem_reg(w_mem_reg),
        .w_rd(w_rd), .stall_d(stall_d), .flush_d(flush_d), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    control_pipeline #(.REG_ADDR_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_alu_op(d_alu_op), .d_alu_src2(d_alu_src2),
        .d_brn_cond(d_brn_cond), .d_mem_we(d_mem_we), .d_de_we(d_de_we), .d_mem_reg(d_mem_reg),
        .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_br_taken(e_br_taken), .e_alu_op(s_e_alu_op), .e_alu_src2(s_e_alu_src2),
        .e_brn_cond(s_e_brn_cond), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .m_mem_we(s_m_mem_we),
        .w_de_we(s_w_de_we), .w_mem_reg(s_w_mem_reg), .w_rd(s_w_rd), .stall_d(s_stall_d),
        .flush_d(s_flush_d), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic       dv;
        logic [1:0] op, src2;
        logic       brn, mwe, dwe, mreg;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2;
    } instr_t;

    typedef struct packed {
        logic [1:0]  op, src2;
        logic        brn;
        logic [1:0]  fa, fb;
        logic        mwe, wwe, wmreg;
        logic [4:0]  wrd;
        logic        stall, flush;
        logic [31:0] scnt, fcnt;
    } exp_t;

    typedef struct packed {
        instr_t d;
        logic   brt;
        exp_t   x;
    } vec_t;

    vec_t rows[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic instr_t NOP();
        instr_t t = '0;
        return t;
    endfunction
    function automatic instr_t ADD(int rd, int rs1, int rs2);
        instr_t t = '0;
        t.dv = 1'b1; t.op = 2'b01; t.dwe = 1'b1;
        t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = 1'b1; t.u2 = 1'b1;
        return t;
    endfunction
    function automatic instr_t LW(int rd, int rs1);
        instr_t t = '0;
        t.dv = 1'b1; t.src2 = 2'b01; t.dwe = 1'b1; t.mreg = 1'b1;
        t.rd = 5'(rd); t.rs1 = 5'(rs1); t.u1 = 1'b1;
        return t;
    endfunction
    function automatic instr_t SW(int rs1, int rs2);
        instr_t t = '0;
        t.dv = 1'b1; t.src2 = 2'b01; t.mwe = 1'b1;
        t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = 1'b1; t.u2 = 1'b1;
        return t;
    endfunction
    function automatic instr_t BEQ(int rs1, int rs2);
        instr_t t = '0;
        t.dv = 1'b1; t.op = 2'b10; t.brn = 1'b1;
        t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = 1'b1; t.u2 = 1'b1;
        return t;
    endfunction

    function automatic exp_t X(int op, int src2, int brn, int fa, int fb, int mwe, int wwe,
                               int wmreg, int wrd, int stall, int flush, int sc, int fc);
        exp_t x;
        x.op = 2'(op); x.src2 = 2'(src2); x.brn = 1'(brn); x.fa = 2'(fa); x.fb = 2'(fb);
        x.mwe = 1'(mwe); x.wwe = 1'(wwe); x.wmreg = 1'(wmreg); x.wrd = 5'(wrd);
        x.stall = 1'(stall); x.flush = 1'(flush); x.scnt = 32'(sc); x.fcnt = 32'(fc);
        return x;
    endfunction

    task automatic add(input instr_t d, input logic brt, input exp_t x);
        vec_t v;
        v.d = d; v.brt = brt; v.x = x;
        rows.push_back(v);
    endtask

    task automatic drive(input instr_t d, input logic brt);
        d_valid = d.dv; d_alu_op = d.op; d_alu_src2 = d.src2; d_brn_cond = d.brn;
        d_mem_we = d.mwe; d_de_we = d.dwe; d_mem_reg = d.mreg;
        d_rd = d.rd; d_rs1 = d.rs1; d_rs2 = d.rs2; d_use_rs1 = d.u1; d_use_rs2 = d.u2;
        e_br_taken = brt;
    endtask

    task automatic drive_rand();
        instr_t t;
        t = instr_t'($urandom);
        drive(t, 1'($urandom));
    endtask

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s [step %0d]: got %0h, required %0h", nm, tag, act, req);
        end
    endtask

    task automatic check_row(input int tag, input exp_t x);
        chk("e_alu_op",   tag, 32'(e_alu_op),   32'(x.op));
        chk("e_alu_src2", tag, 32'(e_alu_src2), 32'(x.src2));
        chk("e_brn_cond", tag, 32'(e_brn_cond), 32'(x.brn));
        chk("fwd_a",      tag, 32'(fwd_a),      32'(x.fa));
        chk("fwd_b",      tag, 32'(fwd_b),      32'(x.fb));
        chk("m_mem_we",   tag, 32'(m_mem_we),   32'(x.mwe));
        chk("w_de_we",    tag, 32'(w_de_we),    32'(x.wwe));
        chk("w_mem_reg",  tag, 32'(w_mem_reg),  32'(x.wmreg));
        chk("w_rd",       tag, 32'(w_rd),       32'(x.wrd));
        chk("stall_d",    tag, 32'(stall_d),    32'(x.stall));
        chk("flush_d",    tag, 32'(flush_d),    32'(x.flush));
        chk("stall_cnt",  tag, stall_cnt,       x.scnt);
        chk("flush_cnt",  tag, flush_cnt,       x.fcnt);
    endtask

    initial begin
        //   D instruction      brt  op src2 brn fa fb mwe wwe wmreg wrd stall flush sc fc
        add(ADD(5, 1, 2),      0, X(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        add(ADD(6, 5, 5),      0, X(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        add(NOP(),             0, X(1, 0, 0, 2, 2, 0, 0, 0, 0,  0, 0, 0, 0));
        add(LW(7, 3),          0, X(0, 0, 0, 0, 0, 0, 1, 0, 5,  0, 0, 0, 0));
        add(ADD(8, 7, 1),      0, X(0, 1, 0, 0, 0, 0, 1, 0, 6,  1, 0, 0, 0));
        add(ADD(8, 7, 1),      0, X(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
        add(NOP(),             0, X(1, 0, 0, 1, 0, 0, 1, 1, 7,  0, 0, 1, 0));
        add(BEQ(1, 2),         0, X(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0));
        add(SW(2, 3),          1, X(2, 0, 1, 0, 0, 0, 1, 0, 8,  0, 1, 1, 0));
        add(SW(4, 5),          0, X(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1));
        add(NOP(),             0, X(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1));
        add(LW(9, 1),          0, X(0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 1));
        add(ADD(10, 9, 9),     1, X(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1));
        add(NOP(),             0, X(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2));
        add(LW(0, 1),          0, X(0, 0, 0, 0, 0, 0, 1, 1, 9,  0, 0, 1, 2));
        add(ADD(11, 0, 0),     0, X(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2));
        add(ADD(0, 1, 2),      0, X(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2));
        add(ADD(12, 0, 11),    0, X(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 2));
        add(ADD(13, 1, 2),     0, X(1, 0, 0, 0, 1, 0, 1, 0, 11, 0, 0, 1, 2));
        add(ADD(13, 1, 2),     0, X(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 1, 2));
        add(ADD(14, 13, 2),    0, X(1, 0, 0, 0, 0, 0, 1, 0, 12, 0, 0, 1, 2));
        add(NOP(),             0, X(1, 0, 0, 2, 0, 0, 1, 0, 13, 0, 0, 1, 2));
        add(NOP(),             0, X(0, 0, 0, 0, 0, 0, 1, 0, 13, 0, 0, 1, 2));

        // Reset held for two edges with random inputs.
        rst = 1'b1;
        drive_rand();
        @(posedge clk); #1;
        drive_rand();
        @(negedge clk);
        check_row(-1, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        drive(NOP(), 1'b0);
        @(negedge clk);
        check_row(-2, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (rows[i]) begin
            @(posedge clk); #1;
            drive(rows[i].d, rows[i].brt);
            @(negedge clk);
            check_row(i, rows[i].x);
        end

        // Reset with a store in E and an ALU op in M: both must vanish.
        @(posedge clk); #1; drive(ADD(15, 1, 2), 1'b0);
        @(posedge clk); #1; drive(SW(1, 2), 1'b0);
        @(posedge clk); #1; rst = 1'b1; drive(ADD(16, 1, 2), 1'b0);
        @(posedge clk); #1; rst = 1'b0; drive(NOP(), 1'b0);
        @(negedge clk);
        check_row(100, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        @(negedge clk);
        check_row(101, X(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // lw x7,(x7) held in decode stalls every other cycle: 20 stalls in 40 cycles.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            drive(LW(7, 7), 1'b0);
            if (i == 28) begin
                @(negedge clk);
                chk("stall_cnt_mid",     i, stall_cnt,          32'd14);
                chk("sat_stall_cnt_mid", i, 32'(s_stall_cnt),   32'd14);
                chk("stall_d_bubble",    i, 32'(stall_d),       32'd0);
            end
            if (i == 29) begin
                @(negedge clk);
                chk("stall_d_repeat",    i, 32'(stall_d),       32'd1);
            end
        end
        @(posedge clk); #1;
        drive(NOP(), 1'b0);
        @(negedge clk);
        chk("stall_cnt_20",  200, stall_cnt,        32'd20);
        chk("sat_stall_cnt", 200, 32'(s_stall_cnt), 32'd15);
        chk("sat_flush_cnt", 200, 32'(s_flush_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
